// File: rtl/regfile_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial register file transfer engine.
// Pure declarations: no latency, no flow control.
package regfile_serial_pkg;

  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_REG_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } xfer_state_t;

  function automatic int addr_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/regfile_serial_xfer_bit_counter.sv
// Bit position counter for serial transfers: counts 0..WIDTH-1 while enabled, wraps to 0.
// Registered index, combinational wrap flag on the last position; no backpressure.
`timescale 1ns/1ps
module serial_bit_counter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  assign wrap = en && (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr || wrap) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_serial_xfer.sv
// Register file with bit-serial read/write-back: start -> REG_WIDTH SHIFT cycles -> COMMIT (done); starts while busy are dropped.
// Parallel stores only in IDLE, rejected with store_rej while busy; REGFILE_SERIAL_MSB_FIRST_EN selects MSB-first bit order.
`timescale 1ns/1ps
module regfile_serial_xfer
  import regfile_serial_pkg::*;
#(
  parameter  int REG_WIDTH = DEF_REG_WIDTH,
  parameter  int REG_COUNT = DEF_REG_COUNT,
  localparam int ADDR_W    = addr_w(REG_COUNT),
  localparam int IDX_W     = idx_w(REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_we,
  input  logic                 rd_bit,
  output logic                 rs1_bit,
  output logic                 rs2_bit,
  output logic [IDX_W-1:0]     bit_index,
  output logic                 busy,
  output logic                 done,
  input  logic                 par_we,
  input  logic [ADDR_W-1:0]    par_addr,
  input  logic [REG_WIDTH-1:0] par_data,
  output logic                 store_rej,
  output logic [REG_WIDTH-1:0] rs1_word
);

  xfer_state_t          state;
  logic [ADDR_W-1:0]    rs1_l;
  logic [ADDR_W-1:0]    rs2_l;
  logic [ADDR_W-1:0]    rd_l;
  logic                 rd_we_l;
  logic [REG_WIDTH-1:0] shadow;
  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic                 in_shift;
  logic                 cnt_wrap;
  logic [IDX_W-1:0]     pos;

  assign in_shift = (state == SHIFT);

  serial_bit_counter #(
    .WIDTH (REG_WIDTH),
    .IDX_W (IDX_W)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (in_shift),
    .clr  (!in_shift),
    .idx  (bit_index),
    .wrap (cnt_wrap)
  );

`ifdef REGFILE_SERIAL_MSB_FIRST_EN
  assign pos = IDX_W'(REG_WIDTH - 1) - bit_index;
`else
  assign pos = bit_index;
`endif

  // regs only change in IDLE/COMMIT, so SHIFT reads always see pre-transfer contents
  assign rs1_bit  = in_shift & regs[rs1_l][pos];
  assign rs2_bit  = in_shift & regs[rs2_l][pos];
  assign rs1_word = regs[rs1_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rs1_l     <= '0;
      rs2_l     <= '0;
      rd_l      <= '0;
      rd_we_l   <= 1'b0;
      shadow    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      store_rej <= 1'b0;
    end else begin
      done      <= 1'b0;
      store_rej <= par_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            rs1_l   <= rs1_addr;
            rs2_l   <= rs2_addr;
            rd_l    <= rd_addr;
            rd_we_l <= rd_we;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shadow[pos] <= rd_bit;
          if (cnt_wrap) begin
            done  <= 1'b1;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Register 0 is never written, which keeps it reading as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == COMMIT) && rd_we_l && (rd_l != '0)) begin
      regs[rd_l] <= shadow;
    end else if ((state == IDLE) && par_we && (par_addr != '0)) begin
      regs[par_addr] <= par_data;
    end
  end

endmodule

// File: tb/tb_regfile_serial_xfer.sv
// Scoreboard bench for regfile_serial_xfer: stimulus queues expected shift bits, done and store_rej
// cycles; a negedge monitor pops and compares them whenever the DUT presents those outputs.
`timescale 1ns/1ps
module tb_regfile_serial_xfer;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_we = 1'b0;
  logic          rd_bit = 1'b0;
  logic          rs1_bit;
  logic          rs2_bit;
  logic [IW-1:0] bit_index;
  logic          busy;
  logic          done;
  logic          par_we = 1'b0;
  logic [AW-1:0] par_addr = '0;
  logic [W-1:0]  par_data = '0;
  logic          store_rej;
  logic [W-1:0]  rs1_word;

  regfile_serial_xfer #(.REG_WIDTH(W), .REG_COUNT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .rd_bit    (rd_bit),
    .rs1_bit   (rs1_bit),
    .rs2_bit   (rs2_bit),
    .bit_index (bit_index),
    .busy      (busy),
    .done      (done),
    .par_we    (par_we),
    .par_addr  (par_addr),
    .par_data  (par_data),
    .store_rej (store_rej),
    .rs1_word  (rs1_word)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          b1;
    logic          b2;
    logic [IW-1:0] idx;
  } bit_exp_t;

  bit_exp_t     bit_q[$];
  int           done_q[$];
  int           rej_q[$];
  logic [W-1:0] mdl [N];

  function automatic int pos_of(input int k);
`ifdef REGFILE_SERIAL_MSB_FIRST_EN
    return W - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations, away from the rising edge.
  always @(negedge clk) begin
    bit_exp_t e;
    int       c;
    if (busy && !done) begin
      if (bit_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL shift_unexpected: shift bits presented with none expected (cycle %0d)", cyc);
      end else begin
        e = bit_q.pop_front();
        check("shift_bits", 32'({rs1_bit, rs2_bit, bit_index}), 32'({e.b1, e.b2, e.idx}));
      end
    end else begin
      check("bits_low_outside_shift", 32'({rs1_bit, rs2_bit}), 32'd0);
    end
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done pulse with none expected (cycle %0d)", cyc);
      end else begin
        c = done_q.pop_front();
        check("done_cycle", cyc, c);
      end
    end
    if (store_rej) begin
      if (rej_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rej_unexpected: store_rej pulse with none expected (cycle %0d)", cyc);
      end else begin
        c = rej_q.pop_front();
        check("store_rej_cycle", cyc, c);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input int a, input logic [W-1:0] exp, input string name);
    rs1_addr = AW'(a);
    #1;
    check(name, 32'(rs1_word), 32'(exp));
  endtask

  task automatic par_store(input int a, input logic [W-1:0] d);
    par_we   = 1'b1;
    par_addr = AW'(a);
    par_data = d;
    if (a != 0) mdl[a] = d;
    next_cycle();
    par_we = 1'b0;
  endtask

  // One serial transfer issued in the current cycle N. Optional extras: parallel store in
  // cycle N, rejected store at bit rej_k, ignored start at bit busy_k, reset at bit abort_k.
  task automatic xfer(input int a1, input int a2, input int ad, input logic we,
                      input logic [W-1:0] stream, input logic st_en, input int st_addr,
                      input logic [W-1:0] st_data, input int rej_k, input int busy_k,
                      input int abort_k);
    int           n0;
    logic [W-1:0] v1;
    logic [W-1:0] v2;
    n0       = cyc;
    start    = 1'b1;
    rs1_addr = AW'(a1);
    rs2_addr = AW'(a2);
    rd_addr  = AW'(ad);
    rd_we    = we;
    if (st_en) begin
      par_we   = 1'b1;
      par_addr = AW'(st_addr);
      par_data = st_data;
      if (st_addr != 0) mdl[st_addr] = st_data;
    end
    v1 = mdl[a1];
    v2 = mdl[a2];
    for (int k = 0; k < W; k++) bit_q.push_back('{v1[pos_of(k)], v2[pos_of(k)], IW'(k)});
    done_q.push_back(n0 + W + 1);
    for (int k = 0; k < W; k++) begin
      next_cycle();
      start  = (k == busy_k);
      par_we = (k == rej_k);
      if (k == rej_k) begin
        par_addr = AW'(st_addr);
        par_data = st_data;
        rej_q.push_back(n0 + k + 2);
      end
      rd_bit = stream[pos_of(k)];
      if (k == abort_k) begin
        rst    = 1'b1;
        start  = 1'b0;
        par_we = 1'b0;
        bit_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) mdl[i] = '0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bit_index", 32'(bit_index), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        return;
      end
    end
    next_cycle();
    start  = 1'b0;
    par_we = 1'b0;
    check("busy_in_commit", 32'(busy), 32'd1);
    check("word_before_commit", 32'(rs1_word), 32'(mdl[a1]));
    if (we && ad != 0) mdl[ad] = stream;
    next_cycle();
    check("busy_after_commit", 32'(busy), 32'd0);
    check("word_after_commit", 32'(rs1_word), 32'(mdl[a1]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = '0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_store_rej", 32'(store_rej), 32'd0);
    check("reset_bit_index", 32'(bit_index), 32'd0);
    check("reset_word", 32'(rs1_word), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // r3 = 0xA5, serial read of r3: LSB-first bits 1,0,1,0,0,1,0,1, done at N+9
    par_store(3, 8'hA5);
    check_word(3, 8'hA5, "r3_par_store");
    xfer(3, 0, 0, 1'b0, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1);

    // write-back of 0x3C into r5 while reading old r5 (0x0F); mid-transfer start ignored
    par_store(5, 8'h0F);
    xfer(5, 3, 5, 1'b1, 8'h3C, 1'b0, 0, 8'h00, -1, 2, -1);
    check_word(5, 8'h3C, "r5_writeback");
    next_cycle();
    check("no_queued_start", 32'(busy), 32'd0);

    // r0 is hardwired zero for serial and parallel writes, without store_rej
    xfer(0, 3, 0, 1'b1, 8'hFF, 1'b0, 0, 8'h00, -1, -1, -1);
    check_word(0, 8'h00, "r0_after_serial");
    par_store(0, 8'h77);
    check_word(0, 8'h00, "r0_after_par");
    next_cycle();

    // parallel store during SHIFT is rejected and leaves r5 alone
    xfer(3, 5, 0, 1'b0, 8'h00, 1'b0, 5, 8'hEE, 3, -1, -1);
    check_word(5, 8'h3C, "r5_after_rejected_store");

    // store and start in the same cycle: SHIFT sees the stored value
    xfer(6, 3, 0, 1'b0, 8'h00, 1'b1, 6, 8'h5A, -1, -1, -1);
    check_word(6, 8'h5A, "r6_store_with_start");

    // single set bit at the top of the word
    par_store(2, 8'h80);
    xfer(2, 2, 0, 1'b0, 8'h00, 1'b0, 0, 8'h00, -1, -1, -1);

    // reset at bit 4 of a write-back: nothing commits, everything clears
    xfer(3, 6, 7, 1'b1, 8'hC3, 1'b0, 0, 8'h00, -1, -1, 4);
    next_cycle();
    rst = 1'b0;
    check_word(7, 8'h00, "r7_after_abort");
    check_word(3, 8'h00, "r3_cleared_by_reset");
    next_cycle();

    // normal operation after reset
    par_store(4, 8'h96);
    xfer(4, 4, 7, 1'b1, 8'h69, 1'b0, 0, 8'h00, -1, -1, -1);
    check_word(7, 8'h69, "r7_writeback_after_reset");

    next_cycle();
    next_cycle();
    check("bit_q_drained", bit_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("rej_q_drained", rej_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
